// File: rtl/demux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// demux_sel_arbiter
//
// Shares the ALU's registered 4-to-16 select demux among NUM_REQ requesters.
// A round-robin arbiter picks one winner in IDLE. It latches that winner's
// select code and drives the demux until the winner drops its request. One
// idle GAP cycle follows each grant so the registered demux output can settle.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-high; clears all state immediately
//   req           per-requester request level
//   req_sel       flattened select codes, requester i at [i*SEL_W +: SEL_W]
//   gnt           one-hot grant (registered)
//   demux_enable  demux enable (registered)
//   demux_sel     latched winner select code (registered)
//   busy          high in ACTIVE and GAP
//   timeout       one-cycle pulse on a forced release
//
// Build option:
//   SEL_ARB_TIMEOUT_EN - when defined, a grant is force-released after
//   MAX_HOLD ACTIVE cycles and timeout pulses. When undefined, a grant lasts
//   until the request drops and timeout is tied to 0.
// -----------------------------------------------------------------------------
module demux_sel_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SEL_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*SEL_W-1:0] req_sel,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     demux_enable,
    output logic [SEL_W-1:0]         demux_sel,
    output logic                     busy,
    output logic                     timeout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    // Reject out-of-range configurations during elaboration.
    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_params
        $error("demux_sel_arbiter: NUM_REQ must be 2..8 and MAX_HOLD must be 1..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t                             state, state_nxt;
    logic [IDX_W-1:0]                   rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]                   winner, winner_nxt;
    logic [7:0]                         hold_cnt, hold_cnt_nxt;
    logic [NUM_REQ-1:0]                 gnt_nxt;
    logic                               enable_nxt;
    logic [SEL_W-1:0]                   sel_nxt;
    logic                               busy_nxt;
    logic                               timeout_nxt;

    // Packed view of the flattened select codes so a code can be picked by index.
    logic [NUM_REQ-1:0][SEL_W-1:0]      req_sel_arr;
    assign req_sel_arr = req_sel;

    // -------------------------------------------------------------------------
    // Round-robin pick: first set request at or above rr_ptr, with wrap-around.
    // -------------------------------------------------------------------------
    logic             found;
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   scan_sum;
    logic [IDX_W-1:0] scan_idx;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        found    = 1'b0;
        pick     = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
            if (scan_sum >= NUM_REQ_W) begin
                scan_sum = scan_sum - NUM_REQ_W;
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    // Pointer for the next round: one past the current winner, wrapping.
    logic [IDX_W:0]   winner_inc;
    logic [IDX_W-1:0] ptr_after_winner;

    always_comb begin
        winner_inc = {1'b0, winner} + (IDX_W + 1)'(1);
        if (winner_inc >= NUM_REQ_W) begin
            ptr_after_winner = '0;
        end else begin
            ptr_after_winner = winner_inc[IDX_W-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Release condition in ACTIVE. Only the winner's request bit is looked at,
    // so unknowns on losing requesters cannot reach the outputs.
    // -------------------------------------------------------------------------
    logic winner_req;
    logic force_release;
    logic release_grant;

    assign winner_req = req[winner];

`ifdef SEL_ARB_TIMEOUT_EN
    assign force_release = winner_req && (hold_cnt == 8'(MAX_HOLD));
`else
    assign force_release = 1'b0;
`endif

    assign release_grant = !winner_req || force_release;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        winner_nxt   = winner;
        hold_cnt_nxt = hold_cnt;
        gnt_nxt      = gnt;
        enable_nxt   = demux_enable;
        sel_nxt      = demux_sel;
        busy_nxt     = busy;
        timeout_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt      = ACTIVE;
                    winner_nxt     = pick;
                    gnt_nxt        = '0;
                    gnt_nxt[pick]  = 1'b1;
                    sel_nxt        = req_sel_arr[pick];
                    enable_nxt     = 1'b1;
                    busy_nxt       = 1'b1;
                    hold_cnt_nxt   = 8'd1;
                end else begin
                    gnt_nxt    = '0;
                    enable_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                end
            end

            ACTIVE: begin
                if (release_grant) begin
                    state_nxt    = GAP;
                    gnt_nxt      = '0;
                    enable_nxt   = 1'b0;
                    busy_nxt     = 1'b1;
                    rr_ptr_nxt   = ptr_after_winner;
                    hold_cnt_nxt = '0;
                    timeout_nxt  = force_release;
                end else if (hold_cnt != 8'hFF) begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end

            GAP: begin
                // demux_sel is left alone: it only changes on a new grant.
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end

            default: begin
                state_nxt  = IDLE;
                gnt_nxt    = '0;
                enable_nxt = 1'b0;
                busy_nxt   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            winner       <= '0;
            hold_cnt     <= '0;
            gnt          <= '0;
            demux_enable <= 1'b0;
            demux_sel    <= '0;
            busy         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed above, independent of statement order.
            state        <= state_nxt;
            rr_ptr       <= rr_ptr_nxt;
            winner       <= winner_nxt;
            hold_cnt     <= hold_cnt_nxt;
            gnt          <= gnt_nxt;
            demux_enable <= enable_nxt;
            demux_sel    <= sel_nxt;
            busy         <= busy_nxt;
            timeout      <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_demux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_demux_sel_arbiter
//
// Directed bench for demux_sel_arbiter with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_demux_sel_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int SEL_W    = 4;
    localparam int MAX_HOLD = 4;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*SEL_W-1:0] req_sel;
    logic [NUM_REQ-1:0]       gnt;
    logic                     demux_enable;
    logic [SEL_W-1:0]         demux_sel;
    logic                     busy;
    logic                     timeout;

    int n_tests = 0;
    int n_fail  = 0;

    demux_sel_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .SEL_W    (SEL_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .req_sel      (req_sel),
        .gnt          (gnt),
        .demux_enable (demux_enable),
        .demux_sel    (demux_sel),
        .busy         (busy),
        .timeout      (timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] exp_gnt,
                              input logic exp_en, input logic exp_busy);
        check({tag, "_gnt"},  32'(gnt),          32'(exp_gnt));
        check({tag, "_en"},   32'(demux_enable), 32'(exp_en));
        check({tag, "_busy"}, 32'(busy),         32'(exp_busy));
    endtask

    task automatic set_code(input int idx, input logic [SEL_W-1:0] code);
        req_sel[idx*SEL_W +: SEL_W] = code;
    endtask

    int w;

    initial begin
        reset   = 1'b1;
        req     = '0;
        req_sel = '0;
        set_code(0, 4'h3);
        set_code(1, 4'h7);
        set_code(2, 4'hA);
        set_code(3, 4'hC);
        step();
        step();

        // Reset values.
        check_outs("reset", 4'b0000, 1'b0, 1'b0);
        check("reset_sel",     32'(demux_sel), 32'h0);
        check("reset_timeout", 32'(timeout),   32'h0);
        reset = 1'b0;

        // Idle with no request stays quiet.
        step();
        check_outs("idle", 4'b0000, 1'b0, 1'b0);

        // Round-robin with all requesters high: order 0,1,2,3,0, two quiet
        // cycles (GAP + IDLE) between grants.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w = k % 4;
            step();
            check("rr_gnt", 32'(gnt), 32'(1) << w);
            check("rr_en_first", 32'(demux_enable), 32'h1);
            step();
            check("rr_en_second", 32'(demux_enable), 32'h1);
            req[w] = 1'b0;
            step();
            check_outs("rr_gap", 4'b0000, 1'b0, 1'b1);
            if (k < 4) req[w] = 1'b1;
            else       req = '0;
            step();
            check_outs("rr_idle", 4'b0000, 1'b0, 1'b0);
        end

        // Reset mid-ACTIVE (rr_ptr is 1 here): grant goes to index 1 first.
        req = 4'b1111;
        step();
        check("pre_reset_gnt", 32'(gnt), 32'b0010);
        check("pre_reset_sel", 32'(demux_sel), 32'h7);
        step();
        #2;
        reset = 1'b1;
        #1;
        check_outs("async_reset", 4'b0000, 1'b0, 1'b0);
        check("async_reset_sel", 32'(demux_sel), 32'h0);
        reset = 1'b0;
        // rr_ptr is back to 0, so with everyone requesting index 0 wins.
        step();
        check("post_reset_gnt", 32'(gnt), 32'b0001);
        check("post_reset_sel", 32'(demux_sel), 32'h3);
        req = '0;
        step();
        step();

        // Single grant to requester 2, held for three sampled cycles; code
        // change and unknown loser requests mid-grant are ignored.
        req = 4'b0100;
        step();
        check_outs("single_1", 4'b0100, 1'b1, 1'b1);
        check("single_sel", 32'(demux_sel), 32'hA);
        set_code(2, 4'h5);
        req = 4'bx1xx;
        step();
        check_outs("single_2", 4'b0100, 1'b1, 1'b1);
        check("single_frozen_sel", 32'(demux_sel), 32'hA);
        req = 4'b0100;
        step();
        check_outs("single_3", 4'b0100, 1'b1, 1'b1);
        req = 4'b0000;
        step();
        check_outs("single_gap", 4'b0000, 1'b0, 1'b1);
        check("single_gap_sel", 32'(demux_sel), 32'hA);
        step();
        check_outs("single_idle", 4'b0000, 1'b0, 1'b0);
        check("single_idle_sel", 32'(demux_sel), 32'hA);

        // Wrap: rr_ptr is 3, only requester 0 asks.
        req = 4'b0001;
        step();
        check("wrap_gnt", 32'(gnt), 32'b0001);
        check("wrap_sel", 32'(demux_sel), 32'h3);
        req = '0;
        step();
        step();

        // One-cycle pulse on requester 1.
        req = 4'b0010;
        step();
        check_outs("pulse_on", 4'b0010, 1'b1, 1'b1);
        req = '0;
        step();
        check_outs("pulse_gap", 4'b0000, 1'b0, 1'b1);
        step();
        check_outs("pulse_idle", 4'b0000, 1'b0, 1'b0);

        // Requester 3 stuck high with requester 0 also waiting (rr_ptr is 2).
        req = 4'b1001;
        step();
        check_outs("stuck_grant", 4'b1000, 1'b1, 1'b1);
        check("stuck_sel", 32'(demux_sel), 32'hC);
`ifdef SEL_ARB_TIMEOUT_EN
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            step();
            check_outs("hold", 4'b1000, 1'b1, 1'b1);
            check("hold_timeout", 32'(timeout), 32'h0);
        end
        step();
        check_outs("forced_release", 4'b0000, 1'b0, 1'b1);
        check("timeout_pulse", 32'(timeout), 32'h1);
        step();
        check_outs("timeout_idle", 4'b0000, 1'b0, 1'b0);
        check("timeout_cleared", 32'(timeout), 32'h0);
        step();
        check("after_timeout_gnt", 32'(gnt), 32'b0001);
        req = '0;
        step();
        step();
`else
        for (int i = 0; i < 12; i++) begin
            step();
            check_outs("no_timeout_hold", 4'b1000, 1'b1, 1'b1);
            check("no_timeout", 32'(timeout), 32'h0);
        end
        req = '0;
        step();
        check_outs("no_timeout_release", 4'b0000, 1'b0, 1'b1);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_sel_arbiter.md
Name: demux_sel_arbiter

Overview:
- Shares the registered 4-to-16 select demux in the ALU among NUM_REQ requesters.
- Each requester asks for one 4-bit select code. The block picks one winner with a round-robin arbiter and latches that winner's code.
- It drives the demux enable and select until the winner releases, then inserts one idle cycle before the next grant.
- It sits between the decode/issue stage and the demux.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SEL_W, 4, select code width; matches the demux input width.
- MAX_HOLD, 8, maximum consecutive ACTIVE cycles per grant (1..255). Used only when SEL_ARB_TIMEOUT_EN is defined.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req  input  NUM_REQ  per-requester request level; held high while the requester wants the demux.
- req_sel  input  NUM_REQ*SEL_W  flattened select codes; requester i uses bits [i*SEL_W +: SEL_W].
- gnt  output  NUM_REQ  one-hot grant, registered.
- demux_enable  output  1  drives the demux enable input.
- demux_sel  output  SEL_W  drives the demux select input; latched winner code.
- busy  output  1  high in ACTIVE and GAP.
- timeout  output  1  one-cycle pulse on a forced release (SEL_ARB_TIMEOUT_EN only; otherwise tied to 0).

Behaviour:
- Reset values:
  - gnt=0, demux_enable=0, demux_sel=0, busy=0, timeout=0.
  - state=IDLE, rr_ptr=0, hold_cnt=0.
  - Asserting reset mid-grant drops every output within the same cycle, with no wait for a clock edge.
- State IDLE:
  - If req==0, stay in IDLE; all outputs 0.
  - If req!=0, the winner is the first set bit scanning upward from index rr_ptr, wrapping past NUM_REQ-1 to 0.
  - On the same edge: gnt=onehot(winner), demux_sel=req_sel[winner], demux_enable=1, busy=1, hold_cnt=1; go to ACTIVE.
- State ACTIVE:
  - demux_sel is frozen. Changes on req_sel are ignored until the next grant.
  - Stay in ACTIVE while req[winner]==1; hold_cnt increments and saturates at 255.
  - When req[winner]==0 is sampled: on that edge gnt=0 and demux_enable=0, busy stays 1, rr_ptr=(winner+1) mod NUM_REQ; go to GAP.
  - Requests from losing requesters have no effect in ACTIVE.
- State GAP:
  - Lasts exactly one cycle with demux_enable=0, so the registered demux output settles.
  - On the next edge go to IDLE with busy=0. Arbitration happens in IDLE on the following edge.
  - demux_sel keeps its last value through GAP and IDLE. It changes only when a new grant is issued.
- Latency:
  - req rising at edge N is sampled at edge N; gnt and demux_enable are high after edge N.
  - The demux registers again, so the decoded output line is valid after edge N+1.
  - Back-to-back grants to different requesters are separated by 2 cycles (GAP + IDLE) with demux_enable=0.
- Boundary conditions:
  - A request that is high for only one cycle, when sampled in IDLE, still gets a one-cycle ACTIVE (demux_enable high for one cycle), then GAP.
  - All requesters high continuously: grants rotate 0,1,2,3,0,... with no starvation.
  - rr_ptr at NUM_REQ-1 with only req[0] set: the scan wraps and req 0 wins.
  - Winner drops req on the same edge another requester raises: release happens normally; the new requester is considered in IDLE.
  - X/unknown on req bits of non-winners during ACTIVE must not affect outputs.

Optional Feature:
- Macro: SEL_ARB_TIMEOUT_EN.
- Defined:
  - In ACTIVE, when hold_cnt==MAX_HOLD and req[winner] is still 1, force a release on that edge: same actions as a normal release, plus timeout=1 for one cycle.
  - rr_ptr advances past the winner, so a stuck requester cannot monopolise the demux. It competes again from IDLE.
- Not defined: no hold counter limit; grants last until req drops; timeout is constant 0.

Test Plan:
- Reset: assert reset mid-ACTIVE with gnt=4'b0010 -> gnt, demux_enable, busy and demux_sel go to 0 asynchronously; after release, req=4'b0001 grants index 0 (rr_ptr back to 0).
- Single grant: req[2]=1 with code 4'hA, held 3 cycles -> gnt=4'b0100, demux_sel=4'hA, demux_enable high for 3 cycles, then 1 GAP cycle; req_sel[2] changed to 4'h5 mid-grant leaves demux_sel at 4'hA.
- Round-robin: req=4'b1111 held high, each winner drops req after 2 cycles then re-raises -> grant order 0,1,2,3,0; demux_enable low for exactly 2 cycles between grants.
- Wrap: rr_ptr=3 (after a grant to index 2), req=4'b0001 -> index 0 granted.
- One-cycle pulse: req[1] high for 1 cycle in IDLE -> demux_enable high for exactly 1 cycle, gnt=4'b0010 for 1 cycle.
- Timeout (SEL_ARB_TIMEOUT_EN, MAX_HOLD=4): req[3] stuck high, req[0] high -> after 4 ACTIVE cycles, timeout pulses once and the next grant goes to index 0. With the macro undefined, req[3] holds the demux indefinitely and timeout stays 0.
